// File: rtl/inst_loader.sv
// inst_loader: writes a host byte stream into instruction memory.
// The stream starts with a 16-bit little-endian word count N, followed by
// N little-endian instruction words. The words are written to addresses
// 0..N-1. The scheduler is held in reset until the last word is written.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends only on the state (and is low while reset is high).
// The host may hold in_valid and in_data steady across cycles where in_ready
// is low, and the byte is taken on the first cycle where in_ready is high.
module inst_loader #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam int BYTES  = INST_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  // Memory depth, one bit wider than the count so that 2^16 fits.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [INST_WIDTH-1:0] word_buf_q, word_buf_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
  logic [INST_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [15:0]           words_loaded_q, words_loaded_d;
  logic [15:0]           n_new;
  logic                  fire;

  // Ready is high only in the byte-accepting states, and never during reset.
  always_comb begin
    in_ready = !reset && ((state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                          (state_q == S_DATA));
  end

  assign fire = in_valid && in_ready;

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    byte_idx_d     = byte_idx_q;
    word_idx_d     = word_idx_q;
    word_buf_d     = word_buf_q;
    mem_we_d       = 1'b0;
    mem_waddr_d    = mem_waddr_q;
    mem_wdata_d    = mem_wdata_q;
    core_reset_d   = core_reset_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    n_new          = {in_data, cnt_q[7:0]};

    case (state_q)
      S_CNT_LO: begin
        if (fire) begin
          cnt_d[7:0] = in_data;
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (fire) begin
          cnt_d = n_new;
          if (n_new == 16'd0) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end else if ({1'b0, n_new} > DEPTH) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            byte_idx_d = '0;
            word_idx_d = 16'd0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_buf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          if (byte_idx_q == LAST_BYTE) begin
            // Launch the write so mem_we is high for the whole WRITE cycle.
            byte_idx_d  = '0;
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_waddr_d = word_idx_q[ADDR_WIDTH-1:0];
            mem_wdata_d = word_buf_d;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        words_loaded_d = word_idx_q + 16'd1;
        if (word_idx_q == cnt_q - 16'd1) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_reset_d = 1'b0;
        end else begin
          word_idx_d = word_idx_q + 16'd1;
          state_d    = S_DATA;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d        = S_CNT_LO;
          core_reset_d   = 1'b1;
          done_d         = 1'b0;
          words_loaded_d = 16'd0;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d = S_CNT_LO;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = S_CNT_LO;
      end
    endcase
  end

  // State and output registers; synchronous reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_CNT_LO;
      cnt_q          <= 16'd0;
      byte_idx_q     <= '0;
      word_idx_q     <= 16'd0;
      word_buf_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= '0;
      mem_wdata_q    <= '0;
      core_reset_q   <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      byte_idx_q     <= byte_idx_d;
      word_idx_q     <= word_idx_d;
      word_buf_q     <= word_buf_d;
      mem_we_q       <= mem_we_d;
      mem_waddr_q    <= mem_waddr_d;
      mem_wdata_q    <= mem_wdata_d;
      core_reset_q   <= core_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of whole-load vectors plus hand-written
// sequences for valid gaps, mid-load reset, restart and a full-memory load.
module tb_inst_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writes: {addr, data}
  logic [39:0] exp_q[$];

  typedef struct packed {
    logic [15:0]      n;
    logic [3:0][31:0] w;
    logic             exp_err;
  } vec_t;

  vec_t vecs [5];

  inst_loader #(.INST_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .start        (start),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every mem_we cycle must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 mem_waddr, mem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          n_errors++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_waddr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Hold reset for n cycles, check reset values, release at a negedge.
  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", in_ready, 1);
  endtask

  // Present a byte, hold it until accepted; returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b);
    int w;
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles, required 1");
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  // Called right after the last data byte: WRITE cycle, then DONE.
  task automatic finish_load(input logic [15:0] n);
    in_valid = 1'b0;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_done", done, 0);
    chk("wr_core_reset", core_reset, 1);
    chk("wr_in_ready", in_ready, 0);
    @(negedge clk);
    chk("done", done, 1);
    chk("done_core_reset", core_reset, 0);
    chk("done_words", words_loaded, n);
    chk("done_in_ready", in_ready, 0);
    chk("exp_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;

    vecs[0].n = 16'd2;   vecs[0].exp_err = 1'b0;
    vecs[0].w = {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678};
    vecs[1].n = 16'd0;   vecs[1].exp_err = 1'b0;
    vecs[1].w = '0;
    vecs[2].n = 16'd257; vecs[2].exp_err = 1'b1;
    vecs[2].w = '0;
    vecs[3].n = 16'd3;   vecs[3].exp_err = 1'b0;
    vecs[3].w = {32'h0, 32'h80000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[4].n = 16'd1;   vecs[4].exp_err = 1'b0;
    vecs[4].w = {32'h0, 32'h0, 32'h0, 32'h0F1E2D3C};

    // Table-driven whole loads, in_valid held high throughout
    for (int v = 0; v < 5; v++) begin
      do_reset(3);
      send_byte(vecs[v].n[7:0]);
      send_byte(vecs[v].n[15:8]);
      if (vecs[v].exp_err) begin
        in_valid = 1'b0;
        chk("err_error", error, 1);
        chk("err_core_reset", core_reset, 1);
        chk("err_in_ready", in_ready, 0);
        chk("err_done", done, 0);
        @(negedge clk);
        chk("err_hold", error, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", error, 0);
        chk("err_rearm_ready", in_ready, 1);
        chk("err_rearm_core_reset", core_reset, 1);
      end else if (vecs[v].n == 16'd0) begin
        in_valid = 1'b0;
        chk("n0_done", done, 1);
        chk("n0_core_reset", core_reset, 0);
        chk("n0_words", words_loaded, 0);
        @(negedge clk);
        chk("n0_in_ready", in_ready, 0);
      end else begin
        for (int i = 0; i < int'(vecs[v].n); i++) begin
          exp_q.push_back({8'(i), vecs[v].w[i]});
          send_word(vecs[v].w[i]);
        end
        finish_load(vecs[v].n);
      end
    end

    // N=1 with in_valid toggling; start pulses in gaps must be ignored
    do_reset(2);
    begin
      logic [7:0] seq [6];
      seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'hEF;
      seq[3] = 8'hCD; seq[4] = 8'hAB; seq[5] = 8'h89;
      exp_q.push_back({8'h00, 32'h89ABCDEF});
      for (int k = 0; k < 6; k++) begin
        send_byte(seq[k]);
        if (k < 5) begin
          in_valid = 1'b0;
          start    = 1'b1;
          chk("gap_in_ready", in_ready, 1);
          @(negedge clk);
          start = 1'b0;
        end
      end
      finish_load(16'd1);
    end

    // Reset after 2 bytes of word 1, then reload CAFEF00D
    do_reset(2);
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({8'h00, 32'h01020304});
    send_word(32'h01020304);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset(1);
    chk("midrst_exp_empty", exp_q.size(), 0);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({8'h00, 32'hCAFEF00D});
    send_word(32'hCAFEF00D);
    finish_load(16'd1);

    // Restart from DONE with start
    do_reset(2);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({8'h00, 32'h11223344});
    send_word(32'h11223344);
    finish_load(16'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_core_reset", core_reset, 1);
    chk("restart_done", done, 0);
    chk("restart_words", words_loaded, 0);
    chk("restart_in_ready", in_ready, 1);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({8'h00, 32'h00000001});
    send_word(32'h00000001);
    finish_load(16'd1);

    // N = 256 fills the memory; last write goes to address FF
    do_reset(2);
    send_byte(8'h00);
    send_byte(8'h01);
    chk("fill_no_error", error, 0);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({8'(i), 32'hA5000000 | 32'(i)});
      send_word(32'hA5000000 | 32'(i));
    end
    chk("fill_last_addr", mem_waddr, 8'hFF);
    finish_load(16'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program-load writer for the instruction memory; the scheduler only reads that memory.
- Receives a byte stream from the host over a valid/ready handshake.
- Assembles the bytes into instruction words and writes them into the memory's write port starting at address 0.
- Holds the scheduler in reset until the whole program has been written.

Parameters:
- INST_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, instruction memory address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte from host.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- start  input  1  re-arm the loader from DONE or ERR.
- mem_we  output  1  instruction memory write enable, one-cycle pulse.
- mem_waddr  output  ADDR_WIDTH  write address.
- mem_wdata  output  INST_WIDTH  write data.
- core_reset  output  1  reset to the scheduler/PC; high until load completes.
- done  output  1  program loaded.
- error  output  1  word count exceeds memory depth.
- words_loaded  output  16  number of words written so far.

Behaviour:
- Reset values: state=CNT_LO, in_ready=0 while reset is high, mem_we=0, mem_waddr=0, mem_wdata=0, core_reset=1, done=0, error=0, words_loaded=0.
- Handshake:
  - A byte transfers on a rising edge where in_valid && in_ready.
  - in_ready is a combinational function of the state: 1 in CNT_LO, CNT_HI and DATA; 0 in WRITE, DONE and ERR.
  - The host may hold in_valid high across ready-low cycles without losing data.
- Stream format:
  - Two count bytes, little-endian: N = {hi, lo}.
  - Then N words, each INST_WIDTH/8 bytes, little-endian (first byte lands in bits [7:0]).
- States:
  - CNT_LO: accept byte -> cnt[7:0], go to CNT_HI.
  - CNT_HI: accept byte -> cnt[15:8].
    - N == 0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR.
    - Otherwise byte_idx=0, word_idx=0, go to DATA.
  - DATA: each accepted byte is shifted into the word buffer at byte_idx*8 and byte_idx increments. On the last byte (byte_idx == INST_WIDTH/8-1) go to WRITE; byte_idx wraps to 0.
  - WRITE (exactly 1 cycle):
    - mem_we=1, mem_waddr=word_idx[ADDR_WIDTH-1:0], mem_wdata=assembled word.
    - words_loaded updates to word_idx+1 at the end of this cycle.
    - If word_idx == N-1 -> DONE; else word_idx++ and return to DATA.
  - DONE: done=1, core_reset=0. start=1 -> CNT_LO with core_reset=1, done=0 and words_loaded=0 on the next cycle.
  - ERR: error=1, core_reset=1, no memory writes. start=1 -> CNT_LO and error clears.
- start is ignored in CNT_LO, CNT_HI, DATA and WRITE.
- Outputs done, error and core_reset are registered: they change on the clock edge that enters or leaves their state.
- mem_waddr/mem_wdata hold their last written values outside WRITE; only mem_we qualifies them.
- Throughput: a word needs INST_WIDTH/8 byte cycles plus 1 write cycle. Back-to-back valid bytes give 5 cycles per 32-bit word.
- N == 2^ADDR_WIDTH is legal and fills the memory; the last address is 2^ADDR_WIDTH-1.
- Reset mid-load: returns to the reset values on the next edge. Partial words are discarded and already-written words are not erased.
- A gap in in_valid in the middle of a word stalls the state without corrupting byte_idx.

Test Plan:
- Reset 3 cycles, then stream 02 00, 78 56 34 12, EF BE AD DE with in_valid constant. Required: mem_we pulses twice, {0, 0x12345678} then {1, 0xDEADBEEF}. done and core_reset go 1/0 on the edge after the second write. words_loaded=2.
- Count 00 00. Required: done=1 on the edge after the second count byte, and mem_we never asserts.
- Count 01 01 (N=257, ADDR_WIDTH=8). Required: error=1, core_reset stays 1, in_ready=0 afterwards. start then clears error and returns to CNT_LO.
- N=1 with in_valid toggling 1/0 every cycle. Required: the word is written correctly and in_ready is low for exactly the one WRITE cycle.
- Assert reset after 2 of the 4 bytes of word 1, then reload N=1 with 0xCAFEF00D. Required: a single write of {0, 0xCAFEF00D}, with no stale bytes merged in.
- Load N=1, reach DONE, pulse start, load N=1 with 0x00000001. Required: core_reset re-asserts on the edge after start, and the second write goes to address 0.
